countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
Parametrised countdown timer controller for the game round clock.
- Generates its own tick from the system clock with an internal prescaler.
- Supports start, pause/resume, clear and runtime load of the start value.
- Provides sticky done, one-cycle done pulse and a low-time warning flag for the display and game FSM.

Parameters:
TIMER_BITS, 6, width of the time value; MAX_TIME must be < 2^TIMER_BITS.
MAX_TIME, 30, value loaded on reset and on clear.
TICK_DIV, 100000000, clk cycles per tick; must be >= 1; prescaler width is max(1, $clog2(TICK_DIV)).
WARN_TIME, 5, warning asserts when 0 < current_time <= WARN_TIME.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (reset == 0 resets)
start  input  1  level-sampled: begin count from IDLE, resume from PAUSE
pause  input  1  level-sampled: freeze count in RUN
clear  input  1  return to IDLE with MAX_TIME
load  input  1  load load_value (honoured in IDLE/DONE only)
load_value  input  TIMER_BITS  value for load
current_time  output  TIMER_BITS  registered remaining time
running  output  1  state == RUN
paused  output  1  state == PAUSE
timer_done  output  1  state == DONE (sticky)
done_pulse  output  1  high exactly one cycle on entry to DONE
warning  output  1  (RUN or PAUSE) and 0 < current_time <= WARN_TIME

Behaviour:
- Reset (async, reset low): state IDLE, current_time = MAX_TIME, prescaler = 0, all flag outputs 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Command priority, per cycle: clear > load > pause > start.
- clear, any state: next state IDLE, current_time = MAX_TIME, prescaler = 0.
- load in IDLE or DONE: current_time = load_value (full range, 0 allowed), state IDLE, prescaler = 0.
- load in RUN or PAUSE: ignored.
- start in IDLE:
  - current_time != 0: go to RUN, prescaler = 0.
  - current_time == 0: go to DONE next cycle, done_pulse fires.
- start in PAUSE: go to RUN; prescaler keeps its partial count (true resume).
- start in RUN or DONE: ignored.
- pause in RUN: go to PAUSE; prescaler and current_time held.
- pause and start together: pause wins (RUN goes to PAUSE; PAUSE stays PAUSE).
- Prescaler advances only in RUN.
  - tick is high when prescaler == TICK_DIV-1 in RUN; prescaler then wraps to 0.
  - TICK_DIV == 1: tick every RUN cycle.
- On tick:
  - current_time > 1: decrement.
  - current_time == 1: current_time = 0 and state = DONE on the same edge; done_pulse is high the following cycle only.
- First decrement occurs TICK_DIV cycles after the edge that enters RUN.
- DONE: current_time stays 0, timer_done stays 1; exit only via clear or load.
- No wrap-around: the counter never decrements below 0.
- warning updates with the registered current_time and is 0 in IDLE and DONE.

Optional Feature:
Macro TIMER_BCD_EN.
- Defined: adds outputs time_tens[3:0] and time_ones[3:0].
  - Registered BCD of the next current_time, so they update on the same edge as current_time.
  - Reset value is the BCD of MAX_TIME.
  - Requires MAX_TIME <= 99 and load_value <= 99; values above 99 give tens = 9, ones = 9.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. TICK_DIV=4, MAX_TIME=30: release reset, pulse start -> running=1; current_time becomes 29 after 4 cycles, 28 after 8; after 120 cycles current_time=0, timer_done=1, done_pulse high 1 cycle.
2. Count to 10, pause 7 cycles, then start -> current_time holds 10 while paused, paused=1; the next decrement uses the remaining prescaler count, not a fresh 4.
3. In IDLE, load with load_value=3, then start -> 2, 1, 0 at 4-cycle spacing. warning=1 from the start of RUN (current_time=3 <= 5); timer_done=1 at 0.
4. load with load_value=0, then start -> DONE next cycle, done_pulse=1 once, current_time stays 0.
5. Assert clear and load together in RUN -> clear wins: IDLE, current_time=30. Drive pause and start together in RUN -> PAUSE. Drive load while paused -> ignored.
6. Assert reset mid-count at current_time=17 -> immediately current_time=30, all flags 0. With TIMER_BCD_EN defined: tens=3, ones=0, then 2/9 after the first tick.

Source files
------------

// File: rtl/countdown_timer_ctrl_if.sv
// rtl/countdown_timer_ctrl_if.sv - command/status bundle for the round countdown timer
// Optional BCD digit outputs exist only when TIMER_BCD_EN is defined.
interface countdown_timer_ctrl_if #(
    parameter int TIMER_BITS = 6
);
    logic                  start;
    logic                  pause;
    logic                  clear;
    logic                  load;
    logic [TIMER_BITS-1:0] load_value;
    logic [TIMER_BITS-1:0] current_time;
    logic                  running;
    logic                  paused;
    logic                  timer_done;
    logic                  done_pulse;
    logic                  warning;
`ifdef TIMER_BCD_EN
    logic [3:0]            time_tens;
    logic [3:0]            time_ones;
`endif

    modport master (
        output start, pause, clear, load, load_value,
        input  current_time, running, paused, timer_done, done_pulse, warning
`ifdef TIMER_BCD_EN
        , input time_tens, time_ones
`endif
    );

    modport slave (
        input  start, pause, clear, load, load_value,
        output current_time, running, paused, timer_done, done_pulse, warning
`ifdef TIMER_BCD_EN
        , output time_tens, time_ones
`endif
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - prescaled countdown timer with pause/resume, load and done/warning flags
// Define TIMER_BCD_EN to add registered BCD tens/ones digits of the remaining time.
module countdown_timer_ctrl #(
    parameter int TIMER_BITS = 6,
    parameter int MAX_TIME   = 30,
    parameter int TICK_DIV   = 100000000,
    parameter int WARN_TIME  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    countdown_timer_ctrl_if.slave     bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]         PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [TIMER_BITS-1:0] MAX_T   = TIMER_BITS'(MAX_TIME);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                r_state;
    logic [TIMER_BITS-1:0] r_time;
    logic [PW-1:0]         r_presc;
    logic                  r_running;
    logic                  r_paused;
    logic                  r_done;
    logic                  r_done_pulse;
    logic                  r_warning;

    state_t                w_nxt_state;
    logic [TIMER_BITS-1:0] w_nxt_time;
    logic [PW-1:0]         w_nxt_presc;
    logic                  w_nxt_warn;

    // Command priority: clear > load > pause > start.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_time  = r_time;
        w_nxt_presc = r_presc;
        if (bus.clear) begin
            w_nxt_state = S_IDLE;
            w_nxt_time  = MAX_T;
            w_nxt_presc = '0;
        end else if (bus.load && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_nxt_state = S_IDLE;
            w_nxt_time  = bus.load_value;
            w_nxt_presc = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_nxt_presc = '0;
                        w_nxt_state = (r_time != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        w_nxt_state = S_PAUSE;
                    end else if (r_presc == PS_LAST) begin
                        w_nxt_presc = '0;
                        if (r_time > TIMER_BITS'(1)) begin
                            w_nxt_time = r_time - TIMER_BITS'(1);
                        end else begin
                            w_nxt_time  = '0;
                            w_nxt_state = S_DONE;
                        end
                    end else begin
                        w_nxt_presc = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (!bus.pause && bus.start) begin
                        w_nxt_state = S_RUN;
                    end
                end
                default: begin
                    w_nxt_state = S_DONE;
                end
            endcase
        end
        w_nxt_warn = (w_nxt_state == S_RUN || w_nxt_state == S_PAUSE) &&
                     (w_nxt_time != '0) && (int'(w_nxt_time) <= WARN_TIME);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_time       <= MAX_T;
            r_presc      <= '0;
            r_running    <= 1'b0;
            r_paused     <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_warning    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_time       <= w_nxt_time;
            r_presc      <= w_nxt_presc;
            r_running    <= (w_nxt_state == S_RUN);
            r_paused     <= (w_nxt_state == S_PAUSE);
            r_done       <= (w_nxt_state == S_DONE);
            r_done_pulse <= (w_nxt_state == S_DONE) && (r_state != S_DONE);
            r_warning    <= w_nxt_warn;
        end
    end

    assign bus.current_time = r_time;
    assign bus.running      = r_running;
    assign bus.paused       = r_paused;
    assign bus.timer_done   = r_done;
    assign bus.done_pulse   = r_done_pulse;
    assign bus.warning      = r_warning;

`ifdef TIMER_BCD_EN
    localparam logic [7:0] BCD_MAX = (MAX_TIME > 99) ? 8'h99 :
                                     {4'(MAX_TIME / 10), 4'(MAX_TIME % 10)};

    function automatic logic [7:0] to_bcd(input logic [TIMER_BITS-1:0] v);
        int unsigned n;
        n = 32'(v);
        if (n > 99) return 8'h99;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    logic [7:0] r_bcd;

    // Built from the next time value so the digits change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd <= BCD_MAX;
        end else begin
            r_bcd <= to_bcd(w_nxt_time);
        end
    end

    assign bus.time_tens = r_bcd[7:4];
    assign bus.time_ones = r_bcd[3:0];
`endif
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - vector table plus scoreboard bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;
    localparam int TB = 6;
    localparam int MT = 30;
    localparam int TD = 4;
    localparam int WT = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_ctrl_if #(.TIMER_BITS(TB)) bus ();

    countdown_timer_ctrl #(
        .TIMER_BITS(TB), .MAX_TIME(MT), .TICK_DIV(TD), .WARN_TIME(WT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          st, pa, cl, ld;
        logic [TB-1:0] lv;
        int            ncyc;
        logic [TB-1:0] t;
        logic          r, p, d, dp, w;
    } vec_t;

    typedef struct {
        int            id;
        logic [TB-1:0] t;
        logic          r, p, d, dp, w;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic st, pa, cl, ld, input int lv, input int n,
                       input int t, input logic r, p, d, dp, w);
        vec_t v;
        v.st = st; v.pa = pa; v.cl = cl; v.ld = ld; v.lv = TB'(lv);
        v.ncyc = n; v.t = TB'(t);
        v.r = r; v.p = p; v.d = d; v.dp = dp; v.w = w;
        vt.push_back(v);
    endtask

    task automatic compare_pop();
        exp_t e;
        logic ok;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        ok = (bus.current_time == e.t) && (bus.running == e.r) && (bus.paused == e.p) &&
             (bus.timer_done == e.d) && (bus.done_pulse == e.dp) && (bus.warning == e.w);
`ifdef TIMER_BCD_EN
        ok = ok && (bus.time_tens == 4'(e.t / 10)) && (bus.time_ones == 4'(e.t % 10));
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vec%0d: got t=%0d run=%b pau=%b done=%b pulse=%b warn=%b, want t=%0d run=%b pau=%b done=%b pulse=%b warn=%b",
                     e.id, bus.current_time, bus.running, bus.paused, bus.timer_done,
                     bus.done_pulse, bus.warning, e.t, e.r, e.p, e.d, e.dp, e.w);
        end
    endtask

    // Entered and left at a falling edge; inputs are held for the first rising edge only.
    task automatic apply(input int id, input vec_t v);
        exp_t e;
        bus.start = v.st; bus.pause = v.pa; bus.clear = v.cl; bus.load = v.ld;
        bus.load_value = v.lv;
        e.id = id; e.t = v.t; e.r = v.r; e.p = v.p; e.d = v.d; e.dp = v.dp; e.w = v.w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        repeat (v.ncyc - 1) @(posedge clk);
        @(negedge clk);
        compare_pop();
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        bus.load_value = '0;

        //  st pa cl ld lv  n   t  r p d dp w
        add(0, 0, 0, 0, 0,  3, 30, 0,0,0,0,0);  // idle holds
        add(1, 0, 0, 0, 0,  1, 30, 1,0,0,0,0);  // start
        add(0, 0, 0, 0, 0,  3, 30, 1,0,0,0,0);  // no tick before 4 cycles
        add(0, 0, 0, 0, 0,  1, 29, 1,0,0,0,0);  // first tick
        add(0, 0, 0, 0, 0,  4, 28, 1,0,0,0,0);
        add(0, 0, 0, 0, 0, 72, 10, 1,0,0,0,0);
        add(0, 0, 0, 0, 0,  2, 10, 1,0,0,0,0);  // prescaler part-way
        add(0, 1, 0, 0, 0,  1, 10, 0,1,0,0,0);  // pause
        add(0, 0, 0, 0, 0,  6, 10, 0,1,0,0,0);
        add(1, 0, 0, 0, 0,  1, 10, 1,0,0,0,0);  // resume
        add(0, 0, 0, 0, 0,  1, 10, 1,0,0,0,0);
        add(0, 0, 0, 0, 0,  1,  9, 1,0,0,0,0);  // resumed prescaler, not fresh
        add(0, 0, 0, 0, 0, 12,  6, 1,0,0,0,0);
        add(0, 0, 0, 0, 0,  4,  5, 1,0,0,0,1);  // warning threshold
        add(1, 1, 0, 0, 0,  1,  5, 0,1,0,0,1);  // pause beats start
        add(0, 0, 0, 1, 3,  1,  5, 0,1,0,0,1);  // load ignored in PAUSE
        add(0, 0, 1, 1, 3,  1, 30, 0,0,0,0,0);  // clear beats load
        add(0, 0, 0, 1, 3,  1,  3, 0,0,0,0,0);
        add(1, 0, 0, 0, 0,  1,  3, 1,0,0,0,1);
        add(0, 0, 0, 0, 0,  4,  2, 1,0,0,0,1);
        add(0, 0, 0, 0, 0,  4,  1, 1,0,0,0,1);
        add(0, 0, 0, 0, 0,  3,  1, 1,0,0,0,1);
        add(0, 0, 0, 0, 0,  1,  0, 0,0,1,1,0);  // done with pulse
        add(0, 0, 0, 0, 0,  1,  0, 0,0,1,0,0);  // pulse only one cycle
        add(1, 0, 0, 0, 0,  1,  0, 0,0,1,0,0);  // start ignored in DONE
        add(0, 0, 0, 1, 7,  1,  7, 0,0,0,0,0);  // load from DONE
        add(0, 0, 0, 1, 0,  1,  0, 0,0,0,0,0);
        add(1, 0, 0, 0, 0,  1,  0, 0,0,1,1,0);  // start at zero
        add(0, 0, 0, 0, 0,  1,  0, 0,0,1,0,0);
        add(0, 0, 0, 0, 0,  3,  0, 0,0,1,0,0);
        add(0, 0, 1, 0, 0,  1, 30, 0,0,0,0,0);
        add(1, 0, 0, 0, 0,  1, 30, 1,0,0,0,0);
        add(0, 0, 0, 0, 0, 52, 17, 1,0,0,0,0);

        repeat (2) @(negedge clk);
        e.id = 100; e.t = TB'(MT); e.r = 0; e.p = 0; e.d = 0; e.dp = 0; e.w = 0;
        sb.push_back(e);
        compare_pop();
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) apply(i, vt[i]);

        // Asynchronous reset mid-count must take effect before any clock edge.
        #2;
        reset = 1'b0;
        #1;
        e.id = 101;
        sb.push_back(e);
        compare_pop();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        e.id = 102;
        sb.push_back(e);
        compare_pop();

        begin
            vec_t v;
            v.st = 1; v.pa = 0; v.cl = 0; v.ld = 0; v.lv = '0; v.ncyc = 1;
            v.t = TB'(MT); v.r = 1; v.p = 0; v.d = 0; v.dp = 0; v.w = 0;
            apply(103, v);
            v.st = 0; v.ncyc = 4; v.t = TB'(MT - 1);
            apply(104, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
